// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and defaults for the VRAM arbiter
package vram_pkg;

  localparam int DEF_ADDR_W = 14;

  typedef logic [2:0] rgb_t;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  localparam rgb_t DEF_CLR_RGB = 3'b000;

endpackage

// File: rtl/vram_clear_seq.sv
// rtl/vram_clear_seq.sv - frame-clear sweep FSM and address counter
// Advances only on cycles where the arbiter grants it the VRAM port.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_grant,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        r_state;
  clr_state_t        w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_done;
  logic              w_last_write;

  assign w_last_write = (r_state == CLR_RUN) && i_grant && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last_write;
      if ((r_state == CLR_IDLE) && i_start) begin
        r_cnt <= '0;
      end else if ((r_state == CLR_RUN) && i_grant) begin
        r_cnt <= w_last_write ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CLR_IDLE: if (i_start) w_next = CLR_RUN;
      CLR_RUN:  if (w_last_write) w_next = CLR_IDLE;
      default:  w_next = CLR_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == CLR_RUN);
    o_done = r_done;
    o_addr = r_cnt;
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: scan-out read > frame clear > pixel writer
// Clear engine is built only when VRAM_CLEAR_EN is defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int   ADDR_W  = DEF_ADDR_W,
  parameter int   DEPTH   = 2**ADDR_W,
  parameter rgb_t CLR_RGB = DEF_CLR_RGB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_blank,
  output logic              rd_valid,
  output logic [2:0]        rd_rgb,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_rgb,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              vram_en,
  output logic              vram_ssr,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [2:0]        vram_di,
  input  logic [2:0]        vram_do
);

  logic              r_rd_valid;
  logic              w_clr_busy;
  logic              w_clr_done;
  logic              w_clr_grant;
  logic [ADDR_W-1:0] w_clr_addr;

  assign w_clr_grant = rst_n & ~rd_req & w_clr_busy;

`ifdef VRAM_CLEAR_EN
  vram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (clr_start),
    .i_grant (w_clr_grant),
    .o_busy  (w_clr_busy),
    .o_done  (w_clr_done),
    .o_addr  (w_clr_addr)
  );
`else
  localparam int unused_depth = DEPTH;
  logic w_unused_clr;
  assign w_clr_busy   = 1'b0;
  assign w_clr_done   = 1'b0;
  assign w_clr_addr   = '0;
  assign w_unused_clr = &{1'b0, clr_start, w_clr_grant};
`endif

  // Priority mux; everything is held off while in reset.
  always_comb begin
    vram_en   = 1'b0;
    vram_we   = 1'b0;
    vram_ssr  = 1'b0;
    vram_addr = rd_addr;
    vram_di   = wr_rgb;
    if (!rst_n) begin
      vram_en = 1'b0;
    end else if (rd_req) begin
      vram_en   = 1'b1;
      vram_ssr  = rd_blank;
      vram_addr = rd_addr;
    end else if (w_clr_busy) begin
      vram_en   = 1'b1;
      vram_we   = 1'b1;
      vram_addr = w_clr_addr;
      vram_di   = CLR_RGB;
    end else if (wr_valid) begin
      vram_en   = 1'b1;
      vram_we   = 1'b1;
      vram_addr = wr_addr;
      vram_di   = wr_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
    end
  end

  assign wr_ready = rst_n & ~rd_req & ~w_clr_busy;
  assign rd_valid = r_rd_valid;
  assign rd_rgb   = vram_do;
  assign clr_busy = w_clr_busy;
  assign clr_done = w_clr_done;

endmodule
